// File: rtl/mini68k_opfetch_if.sv
// Decoded-instruction handshake bundle between the decoder and the operand-fetch stage.
interface mini68k_opfetch_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [2:0]  in_dst;
    logic [2:0]  in_src;
    logic        in_use_imm;
    logic [31:0] in_imm;
    logic [1:0]  in_size;

    modport master (
        output in_valid, in_op, in_dst, in_src, in_use_imm, in_imm, in_size,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_op, in_dst, in_src, in_use_imm, in_imm, in_size,
        output in_ready
    );
endinterface

// File: rtl/mini68k_opfetch.sv
// Operand-fetch / writeback stage around mini68k_alu: owns D0-D7 and the CCR.
// Define MINI68K_OPFETCH_BYPASS_EN to accept the next instruction during writeback.
module mini68k_opfetch #(
    parameter int ALU_LAT = 1,
    parameter int NREGS   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mini68k_opfetch_if.slave     bus,
    output logic [3:0]           alu_op,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    input  logic [31:0]          alu_result,
    input  logic [4:0]           alu_ccr,
    output logic                 done,
    output logic                 err,
    output logic [4:0]           ccr_out,
    input  logic [2:0]           dbg_sel,
    output logic [31:0]          dbg_data
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    localparam logic [1:0] LAT_LAST = 2'(ALU_LAT - 1);
`ifdef MINI68K_OPFETCH_BYPASS_EN
    localparam logic WB_READY = 1'b1;
`else
    localparam logic WB_READY = 1'b0;
`endif

    state_t      state;
    logic        ready_q;
    logic [1:0]  cnt;
    logic [3:0]  op_q;
    logic [2:0]  dst_q;
    logic [1:0]  size_q;
    logic [31:0] dreg [NREGS];

    logic [31:0] wb_val;
    logic [31:0] opnd_a;
    logic [31:0] opnd_b;

    function automatic logic [31:0] size_merge(input logic [31:0] old, input logic [31:0] res,
                                               input logic [1:0] sz);
        case (sz)
            2'b00:   return {old[31:8], res[7:0]};
            2'b01:   return {old[31:16], res[15:0]};
            default: return res;
        endcase
    endfunction

    // N/Z come from the sized result, V/C from the ALU; logical ops leave X alone.
    function automatic logic [4:0] ccr_next(input logic [4:0] cur, input logic [4:0] fl,
                                            input logic [31:0] res, input logic [1:0] sz,
                                            input logic [3:0] op);
        logic n, z, x;
        case (sz)
            2'b00:   begin n = res[7];  z = (res[7:0]  == 8'd0);  end
            2'b01:   begin n = res[15]; z = (res[15:0] == 16'd0); end
            default: begin n = res[31]; z = (res == 32'd0);       end
        endcase
        x = (op == 4'd0 || op == 4'd1 || op == 4'd6 || op == 4'd7) ? fl[4] : cur[4];
        return {x, n, z, fl[1:0]};
    endfunction

    assign wb_val      = size_merge(dreg[dst_q], alu_result, size_q);
    assign bus.in_ready = ready_q;
    assign dbg_data    = dreg[dbg_sel];

    always_comb begin
        opnd_a = dreg[bus.in_dst];
        opnd_b = bus.in_use_imm ? bus.in_imm : dreg[bus.in_src];
`ifdef MINI68K_OPFETCH_BYPASS_EN
        if (state == WB && bus.in_dst == dst_q)
            opnd_a = wb_val;
        if (state == WB && !bus.in_use_imm && bus.in_src == dst_q)
            opnd_b = wb_val;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            cnt     <= 2'd0;
            op_q    <= 4'd0;
            dst_q   <= 3'd0;
            size_q  <= 2'd0;
            alu_op  <= 4'd0;
            alu_a   <= 32'd0;
            alu_b   <= 32'd0;
            done    <= 1'b0;
            err     <= 1'b0;
            ccr_out <= 5'd0;
            for (int i = 0; i < NREGS; i++)
                dreg[i] <= 32'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                EXEC: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == LAT_LAST) begin
                        state   <= WB;
                        done    <= 1'b1;
                        ready_q <= WB_READY;
                    end
                end
                WB: begin
                    dreg[dst_q] <= wb_val;
                    ccr_out     <= ccr_next(ccr_out, alu_ccr, alu_result, size_q, op_q);
                    state       <= IDLE;
                    ready_q     <= 1'b1;
                end
                default: ;
            endcase
            // Acceptance overrides the WB -> IDLE return when back-to-back issue is enabled.
            if (bus.in_valid && ready_q) begin
                if (bus.in_size == 2'b11) begin
                    err <= 1'b1;
                end else begin
                    alu_op  <= bus.in_op;
                    alu_a   <= opnd_a;
                    alu_b   <= opnd_b;
                    op_q    <= bus.in_op;
                    dst_q   <= bus.in_dst;
                    size_q  <= bus.in_size;
                    cnt     <= 2'd0;
                    state   <= EXEC;
                    ready_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/mini68k_opfetch.md
Name: mini68k_opfetch

Overview:
- Operand-fetch / writeback stage wrapped around mini68k_alu.
- Holds the data register file D0–D7 and the architectural CCR.
- Accepts one decoded instruction per handshake and drives registered operands and the opcode into the ALU.
- Samples the ALU result and flags, then writes the sized result back to the destination register and CCR.

Parameters:
- ALU_LAT, 1, clock cycles from stable ALU inputs to a valid ALU result/ccr; legal range 1–4.
- NREGS, 8, number of data registers; fixed at 8, since register fields are 3 bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage can accept an instruction.
- in_op  in  4  ALU opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 6 LSL, 7 LSR.
- in_dst  in  3  destination register index; also the source of operand A.
- in_src  in  3  source register index for operand B.
- in_use_imm  in  1  operand B taken from in_imm instead of D[in_src].
- in_imm  in  32  immediate operand.
- in_size  in  2  00 byte, 01 word, 10 long, 11 illegal.
- alu_op  out  4  to ALU op.
- alu_a  out  32  to ALU a.
- alu_b  out  32  to ALU b.
- alu_result  in  32  from ALU result.
- alu_ccr  in  5  from ALU ccr, bit order {X,N,Z,V,C}.
- done  out  1  one-cycle pulse at writeback.
- err  out  1  one-cycle pulse when an illegal size is rejected.
- ccr_out  out  5  architectural CCR {X,N,Z,V,C}.
- dbg_sel  in  3  debug register select.
- dbg_data  out  32  D[dbg_sel], combinational read of the register file.

Behaviour:
- One clock, synchronous active-high reset: `clk` and `rst` (rst sampled on the rising edge of clk).
- Reset values:
  - D0–D7 = 0, ccr_out = 0.
  - alu_op/alu_a/alu_b = 0.
  - done = 0, err = 0, in_ready = 1.
  - State = IDLE.
- Reset mid-instruction abandons it: no register or CCR write, no done pulse.
- State machine: IDLE, EXEC, WB.
  - IDLE: in_ready = 1.
    - On in_valid with in_size = 11: err pulses next cycle; no state change; no register or CCR write.
    - On in_valid with a legal size: latch op, dst, size, use_imm, immediate.
      - alu_a <= D[in_dst].
      - alu_b <= in_use_imm ? in_imm : D[in_src].
      - alu_op <= in_op.
      - Go to EXEC; cycle counter = 0.
  - EXEC: in_ready = 0; alu_* held stable. Counter increments each cycle; after ALU_LAT cycles in EXEC, go to WB.
  - WB:
    - Sample alu_result/alu_ccr.
    - Write D[dst] on this edge with size merge:
      - byte: {old[31:8], res[7:0]}.
      - word: {old[31:16], res[15:0]}.
      - long: res.
    - CCR update:
      - N = MSB of the sized result; Z = (sized result == 0).
      - V, C copied from alu_ccr.
      - X copied from alu_ccr[4] for ops 0, 1, 6, 7; X is unchanged for ops 2, 3, 4.
    - done = 1 for this cycle. Next state IDLE.
- Timing: handshake at cycle T → done at T+ALU_LAT+1 → in_ready high again at T+ALU_LAT+2.
- Unused opcodes (5, 8–15) are passed to the ALU unchanged; writeback proceeds normally.
- dbg_data reflects register writes from the cycle after the write edge.
- When src == dst, both operands read the same pre-instruction value.

Optional Feature:
- MINI68K_OPFETCH_BYPASS_EN defined:
  - in_ready is also 1 in WB, so a new instruction can be accepted in the WB cycle (back-to-back issue, one instruction per ALU_LAT+1 cycles).
  - If the new instruction's dst or (non-immediate) src equals the register being written in WB, the operand uses the merged writeback value, not the stale register.
  - An illegal size accepted in WB pulses err and returns to IDLE after the current writeback completes.
- Undefined: in_ready = 1 only in IDLE; no bypass path exists.

Test Plan:
- Reset: assert rst 2 cycles, then dbg_sel = 0..7 → every D = 0, ccr_out = 0, in_ready = 1, done = 0.
- Immediate ADD long (ALU_LAT = 1): D1 = 0x10, then ADD dst = 1 with imm 0x20 → done 2 cycles after handshake, D1 = 0x30, ccr_out = 00000.
- Byte-size SUB: D2 = 0x12345605, SUB.B dst = 2 imm 0x05 → D2 = 0x12345600, Z = 1, N = 0; upper 24 bits preserved.
- X retention: LSL long D3 = 0x80000000 by 1 (X = C = 1 from ALU) → X = 1; then AND D3 with D3 → X still 1, Z = 1.
- Illegal size: in_size = 11 → err pulses once, no done, all registers unchanged; the next legal instruction is accepted.
- Bypass build: ADD D4 += 1 issued back-to-back twice from D4 = 7 → second accepted in the first's WB cycle, final D4 = 9; non-bypass build gives the same value with one extra idle cycle.
- Reset during EXEC: assert rst → no done pulse, destination register = 0.
